picorv32_to_freeahb_adapter: RTL and testbench

Bridge between the PicoRV32 native memory interface and the FreeAHB master's user-side request interface. It converts each PicoRV32 `mem_valid` request into exactly one single-beat FreeAHB read or write, then returns completion to the core with a one-cycle `mem_ready`. It sits between the CPU core and the FreeAHB master inside the RISC-V/GRLIB subsystem.

---
 rtl/picorv32_freeahb_pkg.sv | 23 ++
 rtl/picorv32_freeahb_strb_decode.sv | 32 +++
 rtl/picorv32_to_freeahb_adapter.sv | 124 ++++++++++++
 tb/tb_picorv32_to_freeahb_adapter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv32_freeahb_pkg.sv
// Shared types and constants for the PicoRV32 to FreeAHB bridge.
package picorv32_freeahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_REQ = 2'd1,
    ST_WR_REQ = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HPROT_UPPER = 2'b00;
  localparam logic       HPROT_PRIV  = 1'b1;

  // HPROT[0] is 0 for an opcode fetch, 1 for a data access.
  function automatic logic [3:0] hprot(input logic instr);
    return {HPROT_UPPER, HPROT_PRIV, ~instr};
  endfunction

endpackage

// File: rtl/picorv32_freeahb_strb_decode.sv
// Byte-strobe to HSIZE/address-offset decode for writes.
// Sub-word decode is enabled by PICO_FREEAHB_SUBWORD_EN; otherwise every write is a word.
module picorv32_freeahb_strb_decode
  import picorv32_freeahb_pkg::*;
(
  input  logic [3:0] wstrb_i,
  output logic [2:0] size_o,
  output logic [1:0] offset_o
);

`ifdef PICO_FREEAHB_SUBWORD_EN
  always_comb begin
    size_o   = HSIZE_WORD;
    offset_o = 2'd0;
    unique case (wstrb_i)
      4'b0001: begin size_o = HSIZE_BYTE; offset_o = 2'd0; end
      4'b0010: begin size_o = HSIZE_BYTE; offset_o = 2'd1; end
      4'b0100: begin size_o = HSIZE_BYTE; offset_o = 2'd2; end
      4'b1000: begin size_o = HSIZE_BYTE; offset_o = 2'd3; end
      4'b0011: begin size_o = HSIZE_HALF; offset_o = 2'd0; end
      4'b1100: begin size_o = HSIZE_HALF; offset_o = 2'd2; end
      default: begin size_o = HSIZE_WORD; offset_o = 2'd0; end
    endcase
  end
`else
  logic unused_strb;
  assign unused_strb = ^wstrb_i;
  assign size_o      = HSIZE_WORD;
  assign offset_o    = 2'd0;
`endif

endmodule

// File: rtl/picorv32_to_freeahb_adapter.sv
// PicoRV32 native memory port to FreeAHB master request bridge, one single-beat transfer per request.
// Sub-word write sizing is controlled by PICO_FREEAHB_SUBWORD_EN (see picorv32_freeahb_strb_decode).
module picorv32_to_freeahb_adapter
  import picorv32_freeahb_pkg::*;
(
  input  logic        freeahb_clk,
  input  logic        freeahb_resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        freeahb_valid,
  output logic [31:0] freeahb_addr,
  output logic [2:0]  freeahb_size,
  output logic        freeahb_write,
  output logic        freeahb_read,
  output logic [31:0] freeahb_wdata,
  output logic [31:0] freeahb_min_len,
  output logic        freeahb_cont,
  output logic [3:0]  freeahb_prot,
  output logic        freeahb_lock,
  input  logic        freeahb_next,
  input  logic        freeahb_ready,
  input  logic [31:0] freeahb_rdata,
  input  logic [31:0] freeahb_result_addr
);

  state_e      state_q;
  logic        mem_ready_q;
  logic [31:0] mem_rdata_q;
  logic        valid_q;
  logic        write_q;
  logic        read_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  size_q;
  logic [3:0]  prot_q;

  logic [2:0]  wr_size;
  logic [1:0]  wr_offset;

  picorv32_freeahb_strb_decode u_strb_decode (
    .wstrb_i  (mem_wstrb),
    .size_o   (wr_size),
    .offset_o (wr_offset)
  );

  always_ff @(posedge freeahb_clk or negedge freeahb_resetn) begin
    if (!freeahb_resetn) begin
      state_q     <= ST_IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= HSIZE_WORD;
      prot_q      <= '0;
    end else begin
      mem_ready_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            valid_q <= 1'b1;
            wdata_q <= mem_wdata;
            prot_q  <= hprot(mem_instr);
            if (mem_wstrb == 4'b0000) begin
              read_q  <= 1'b1;
              addr_q  <= {mem_addr[31:2], 2'b00};
              size_q  <= HSIZE_WORD;
              state_q <= ST_RD_REQ;
            end else begin
              write_q <= 1'b1;
              addr_q  <= {mem_addr[31:2], wr_offset};
              size_q  <= wr_size;
              state_q <= ST_WR_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          if (freeahb_ready) begin
            mem_rdata_q <= freeahb_rdata;
            mem_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            read_q      <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        ST_WR_REQ: begin
          if (freeahb_next) begin
            mem_ready_q <= 1'b1;
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = mem_rdata_q;
  assign freeahb_valid   = valid_q;
  assign freeahb_write   = write_q;
  assign freeahb_read    = read_q;
  assign freeahb_addr    = addr_q;
  assign freeahb_wdata   = wdata_q;
  assign freeahb_size    = size_q;
  assign freeahb_prot    = prot_q;
  assign freeahb_min_len = '0;
  assign freeahb_cont    = 1'b0;
  assign freeahb_lock    = 1'b0;

  // Reads are always word-aligned, so the low address bits never reach the bus.
  logic unused_inputs;
  assign unused_inputs = ^{freeahb_result_addr, mem_addr[1:0]};

endmodule

// File: tb/tb_picorv32_to_freeahb_adapter.sv
// Directed self-checking bench for picorv32_to_freeahb_adapter (expectations follow PICO_FREEAHB_SUBWORD_EN).
module tb_picorv32_to_freeahb_adapter;

`ifdef PICO_FREEAHB_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        f_valid;
  logic [31:0] f_addr;
  logic [2:0]  f_size;
  logic        f_write;
  logic        f_read;
  logic [31:0] f_wdata;
  logic [31:0] f_min_len;
  logic        f_cont;
  logic [3:0]  f_prot;
  logic        f_lock;
  logic        f_next = 1'b0;
  logic        f_ready = 1'b0;
  logic [31:0] f_rdata = '0;
  logic [31:0] f_result_addr = 32'hDEAD_BEEF;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  picorv32_to_freeahb_adapter dut (
    .freeahb_clk         (clk),
    .freeahb_resetn      (rst_n),
    .mem_valid           (mem_valid),
    .mem_instr           (mem_instr),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_wstrb           (mem_wstrb),
    .mem_ready           (mem_ready),
    .mem_rdata           (mem_rdata),
    .freeahb_valid       (f_valid),
    .freeahb_addr        (f_addr),
    .freeahb_size        (f_size),
    .freeahb_write       (f_write),
    .freeahb_read        (f_read),
    .freeahb_wdata       (f_wdata),
    .freeahb_min_len     (f_min_len),
    .freeahb_cont        (f_cont),
    .freeahb_prot        (f_prot),
    .freeahb_lock        (f_lock),
    .freeahb_next        (f_next),
    .freeahb_ready       (f_ready),
    .freeahb_rdata       (f_rdata),
    .freeahb_result_addr (f_result_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " valid"}, 32'(f_valid), 32'd0);
    check({tag, " read"},  32'(f_read),  32'd0);
    check({tag, " write"}, 32'(f_write), 32'd0);
    check({tag, " addr"},  f_addr,       32'd0);
    check({tag, " wdata"}, f_wdata,      32'd0);
    check({tag, " size"},  32'(f_size),  32'd2);
    check({tag, " prot"},  32'(f_prot),  32'd0);
    check({tag, " ready"}, 32'(mem_ready), 32'd0);
    check({tag, " rdata"}, mem_rdata,    32'd0);
  endtask

  typedef struct {
    logic [3:0]  strb;
    logic [2:0]  size_sub;
    logic [31:0] addr_sub;
  } wvec_t;

  wvec_t wvecs [6] = '{
    '{4'b0001, 3'b000, 32'h0000_0100},
    '{4'b0010, 3'b000, 32'h0000_0101},
    '{4'b1000, 3'b000, 32'h0000_0103},
    '{4'b0011, 3'b001, 32'h0000_0100},
    '{4'b1111, 3'b010, 32'h0000_0100},
    '{4'b0110, 3'b010, 32'h0000_0100}
  };

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("min_len", f_min_len, 32'd0);
    check("cont", 32'(f_cont), 32'd0);
    check("lock", 32'(f_lock), 32'd0);
    rst_n = 1'b1;
    step();

    // Read with two stall cycles; mem_valid drops mid-transfer
    mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    step();
    check("rd valid", 32'(f_valid), 32'd1);
    check("rd read",  32'(f_read),  32'd1);
    check("rd write", 32'(f_write), 32'd0);
    check("rd addr",  f_addr,       32'h8000_0000);
    check("rd size",  32'(f_size),  32'd2);
    check("rd prot",  32'(f_prot),  32'd3);
    mem_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rd stall valid", 32'(f_valid), 32'd1);
      check("rd stall ready", 32'(mem_ready), 32'd0);
    end
    f_ready = 1'b1; f_rdata = 32'hAAAA_FFFF;
    step();
    check("rd done ready", 32'(mem_ready), 32'd1);
    check("rd done rdata", mem_rdata, 32'hAAAA_FFFF);
    check("rd done valid", 32'(f_valid), 32'd0);
    check("rd done read",  32'(f_read),  32'd0);
    f_ready = 1'b0;
    step();
    check("rd pulse end", 32'(mem_ready), 32'd0);

    // freeahb_ready outside RD_REQ is ignored
    f_ready = 1'b1; f_rdata = 32'h1234_5678;
    step();
    check("stray ready rdata", mem_rdata, 32'hAAAA_FFFF);
    check("stray ready mready", 32'(mem_ready), 32'd0);
    f_ready = 1'b0;

    // Write with next already high: one-cycle valid
    f_next = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h8000_0000; mem_wdata = 32'hF0FF_0FAA;
    mem_wstrb = 4'b1100; mem_instr = 1'b1;
    step();
    check("wr valid", 32'(f_valid), 32'd1);
    check("wr write", 32'(f_write), 32'd1);
    check("wr read",  32'(f_read),  32'd0);
    check("wr addr",  f_addr, SUBWORD ? 32'h8000_0002 : 32'h8000_0000);
    check("wr size",  32'(f_size), SUBWORD ? 32'd1 : 32'd2);
    check("wr wdata", f_wdata, 32'hF0FF_0FAA);
    check("wr prot",  32'(f_prot), 32'd2);
    mem_valid = 1'b0;
    step();
    check("wr done valid", 32'(f_valid), 32'd0);
    check("wr done write", 32'(f_write), 32'd0);
    check("wr done ready", 32'(mem_ready), 32'd1);
    check("wr keeps rdata", mem_rdata, 32'hAAAA_FFFF);
    f_next = 1'b0;
    step();
    check("wr pulse end", 32'(mem_ready), 32'd0);

    // Byte write, stalled five cycles while mem_* inputs change
    mem_valid = 1'b1; mem_addr = 32'h8000_0010; mem_wdata = 32'h00CC_0000;
    mem_wstrb = 4'b0100; mem_instr = 1'b0;
    step();
    check("bw addr", f_addr, SUBWORD ? 32'h8000_0012 : 32'h8000_0010);
    check("bw size", 32'(f_size), SUBWORD ? 32'd0 : 32'd2);
    check("bw prot", 32'(f_prot), 32'd3);
    mem_valid = 1'b0; mem_addr = 32'h1111_1111; mem_wdata = 32'h2222_2222; mem_wstrb = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall valid", 32'(f_valid), 32'd1);
      check("stall mready", 32'(mem_ready), 32'd0);
    end
    check("stall addr held", f_addr, SUBWORD ? 32'h8000_0012 : 32'h8000_0010);
    check("stall wdata held", f_wdata, 32'h00CC_0000);
    f_next = 1'b1;
    step();
    check("stall done ready", 32'(mem_ready), 32'd1);
    check("stall done valid", 32'(f_valid), 32'd0);
    f_next = 1'b0;
    step();

    // Strobe decode table
    f_next = 1'b1;
    foreach (wvecs[k]) begin
      mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = wvecs[k].strb;
      step();
      mem_valid = 1'b0;
      check($sformatf("strb %b size", wvecs[k].strb), 32'(f_size),
            SUBWORD ? 32'(wvecs[k].size_sub) : 32'd2);
      check($sformatf("strb %b addr", wvecs[k].strb), f_addr,
            SUBWORD ? wvecs[k].addr_sub : 32'h0000_0100);
      step();
      check($sformatf("strb %b mready", wvecs[k].strb), 32'(mem_ready), 32'd1);
      step();
    end
    f_next = 1'b0;

    // Reset during RD_REQ, then a fresh fetch
    mem_valid = 1'b1; mem_addr = 32'h8000_0040; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    mem_wdata = 32'h0;
    step();
    check("pre-reset valid", 32'(f_valid), 32'd1);
    mem_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    #2;
    rst_n = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h1000_0006; mem_instr = 1'b1;
    step();
    check("fetch valid", 32'(f_valid), 32'd1);
    check("fetch addr",  f_addr, 32'h1000_0004);
    check("fetch prot",  32'(f_prot), 32'd2);
    mem_valid = 1'b0;
    f_ready = 1'b1; f_rdata = 32'h5A5A_0001;
    step();
    check("fetch ready", 32'(mem_ready), 32'd1);
    check("fetch rdata", mem_rdata, 32'h5A5A_0001);
    f_ready = 1'b0;
    step();

    // Back-to-back reads with mem_valid and freeahb_ready held high
    mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_instr = 1'b0; f_ready = 1'b1;
    f_rdata = 32'hCAFE_0001;
    step();
    check("b2b1 valid", 32'(f_valid), 32'd1);
    step();
    check("b2b1 ready", 32'(mem_ready), 32'd1);
    check("b2b1 valid low", 32'(f_valid), 32'd0);
    f_rdata = 32'hCAFE_0002;
    step();
    check("b2b idle ready", 32'(mem_ready), 32'd0);
    check("b2b idle valid", 32'(f_valid), 32'd0);
    step();
    check("b2b2 valid", 32'(f_valid), 32'd1);
    check("b2b2 no ready", 32'(mem_ready), 32'd0);
    mem_valid = 1'b0;
    step();
    check("b2b2 ready", 32'(mem_ready), 32'd1);
    check("b2b2 rdata", mem_rdata, 32'hCAFE_0002);
    f_ready = 1'b0;
    step();
    check("b2b2 pulse end", 32'(mem_ready), 32'd0);
    check("b2b final idle", 32'(f_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
